// File: rtl/tx_skp_inserter_if.sv
// Upstream link-layer handshake and downstream scrambler word bundle for
// tx_skp_inserter. The slave modport is the inserter's view; the master
// modport is the view of whatever feeds it and consumes its output.
interface tx_skp_inserter_if;
    logic [31:0] s_data_i;
    logic [3:0]  s_datak_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] indata_o;
    logic [3:0]  datak_o;
    logic [1:0]  data_len_o;
    logic        out_valid_o;

    modport slave (
        input  s_data_i,
        input  s_datak_i,
        input  s_valid_i,
        output s_ready_o,
        output indata_o,
        output datak_o,
        output data_len_o,
        output out_valid_o
    );

    modport master (
        output s_data_i,
        output s_datak_i,
        output s_valid_i,
        input  s_ready_o,
        input  indata_o,
        input  datak_o,
        input  data_len_o,
        input  out_valid_o
    );
endinterface

// File: rtl/tx_skp_inserter.sv
// tx_skp_inserter: sits in front of the scrambler and injects a Gen1/2 SKP
// ordered set (COM SKP SKP SKP) every SKP_INTERVAL cycles, filling empty
// cycles with logical idle. All data outputs are registered.
//
// Handshake: a word transfers on a rising edge where s_valid_i & s_ready_o.
// s_ready_o drops only in the single cycle the SKP OS is being loaded; the
// upstream must then hold its word, which is taken on the following edge.
//
// Optional macro TXSKP_PKT_GUARD_EN: track STP..END/EDB packet framing and
// defer SKP insertion until the packet has ended. Without it a SKP request
// is serviced on the very next cycle regardless of framing.
//
// SKP_INTERVAL must lie in 4..65535.
module tx_skp_inserter #(
    parameter int unsigned SKP_INTERVAL = 295
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    tx_skp_inserter_if.slave bus,
    output logic            skp_ovf_o
);

    localparam logic [15:0] CNT_TERM = 16'(SKP_INTERVAL - 1);
    localparam logic [31:0] SKP_WORD = 32'h1C1C1CBC;

    logic [15:0] r_cnt;
    logic        r_pending;
    logic        r_ovf;
    logic [31:0] r_data;
    logic [3:0]  r_datak;
    logic        r_out_valid;

    logic        w_term;
    logic        w_in_pkt;
    logic        w_skp_now;
    logic        w_accept;

    assign w_term    = (r_cnt == CNT_TERM);
    assign w_skp_now = r_pending & ~w_in_pkt;
    assign w_accept  = bus.s_valid_i & ~w_skp_now;

    assign bus.s_ready_o   = ~w_skp_now;
    assign bus.indata_o    = r_data;
    assign bus.datak_o     = r_datak;
    assign bus.out_valid_o = r_out_valid;
    assign bus.data_len_o  = 2'b10;
    assign skp_ovf_o       = r_ovf;

    // Free-running interval counter; it never pauses for SKP or stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // SKP request flag plus sticky overflow when a request lands on an
    // unserviced one. A new request at the service cycle keeps it set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_term) begin
                r_pending <= 1'b1;
            end else if (w_skp_now) begin
                r_pending <= 1'b0;
            end
            if (w_term && r_pending && !w_skp_now) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef TXSKP_PKT_GUARD_EN
    logic r_in_pkt;
    logic w_stp;
    logic w_end;

    assign w_stp = bus.s_datak_i[0] && (bus.s_data_i[7:0] == 8'hFB);

    // Any K byte carrying END (FD) or EDB (FE) terminates the packet.
    always_comb begin
        w_end = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (bus.s_datak_i[b] &&
                ((bus.s_data_i[8*b +: 8] == 8'hFD) || (bus.s_data_i[8*b +: 8] == 8'hFE))) begin
                w_end = 1'b1;
            end
        end
    end

    // Packet framing state. STP can only sit in byte 0, so any END/EDB in
    // the same word is at a higher byte and closes the packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_in_pkt <= 1'b0;
        end else if (w_accept) begin
            if (w_end) begin
                r_in_pkt <= 1'b0;
            end else if (w_stp) begin
                r_in_pkt <= 1'b1;
            end
        end
    end

    assign w_in_pkt = r_in_pkt;
`else
    assign w_in_pkt = 1'b0;
`endif

    // Output word register: SKP OS, then accepted data, then idle fill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data      <= '0;
            r_datak     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_skp_now) begin
            r_data      <= SKP_WORD;
            r_datak     <= 4'b1111;
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_data      <= bus.s_data_i;
            r_datak     <= bus.s_datak_i;
            r_out_valid <= 1'b1;
        end else begin
            r_data      <= '0;
            r_datak     <= '0;
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Self-checking bench for tx_skp_inserter with SKP_INTERVAL = 8. A
// behavioural model derives SKP request times from the cycle count since
// reset release and packet framing from the accepted symbols.
module tb_tx_skp_inserter;

    localparam int unsigned N = 8;
    localparam logic [31:0] SKP = 32'h1C1C1CBC;
`ifdef TXSKP_PKT_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic skp_ovf;
    always #5 clk = ~clk;

    tx_skp_inserter_if bus ();

    tx_skp_inserter #(.SKP_INTERVAL(N)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .skp_ovf_o (skp_ovf)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_cyc;
    logic        m_pend, m_inpkt, m_ovf;
    logic [31:0] m_data;
    logic [3:0]  m_k;
    logic        m_vld, m_is_data;
    logic [35:0] exp_q[$];

    logic        t_hold;
    logic [31:0] t_hd;
    logic [3:0]  t_hk;

    function automatic logic m_skp_now();
        return m_pend && !m_inpkt;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_pend = 0; m_inpkt = 0; m_ovf = 0;
        m_data = '0; m_k = '0; m_vld = 0; m_is_data = 0;
        exp_q.delete();
        t_hold = 0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic v, input logic [31:0] d, input logic [3:0] k);
        logic skp, acc, term, has_end, stp;
        skp  = m_skp_now();
        acc  = v && !skp;
        m_cyc++;
        term = ((m_cyc % N) == 0);
        if (skp) begin
            m_data = SKP; m_k = 4'hF; m_vld = 1; m_is_data = 0;
        end else if (acc) begin
            m_data = d; m_k = k; m_vld = 1; m_is_data = 1;
            exp_q.push_back({k, d});
        end else begin
            m_data = '0; m_k = '0; m_vld = 0; m_is_data = 0;
        end
        if (term && m_pend && !skp) m_ovf = 1;
        m_pend = term || (m_pend && !skp);
        if (GUARD && acc) begin
            has_end = 0;
            for (int b = 0; b < 4; b++)
                if (k[b] && (d[8*b +: 8] == 8'hFD || d[8*b +: 8] == 8'hFE)) has_end = 1;
            stp = k[0] && (d[7:0] == 8'hFB);
            if (has_end) m_inpkt = 0;
            else if (stp) m_inpkt = 1;
        end
    endtask

    task automatic check_outputs();
        chk("indata",    {32'd0, bus.indata_o},   {32'd0, m_data});
        chk("datak",     {60'd0, bus.datak_o},    {60'd0, m_k});
        chk("out_valid", {63'd0, bus.out_valid_o}, {63'd0, m_vld});
        chk("s_ready",   {63'd0, bus.s_ready_o},  {63'd0, !m_skp_now()});
        chk("skp_ovf",   {63'd0, skp_ovf},        {63'd0, m_ovf});
        chk("data_len",  {62'd0, bus.data_len_o}, {62'd0, 2'b10});
        if (m_is_data) begin
            if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else chk("sb_word", {28'd0, bus.datak_o, bus.indata_o}, {28'd0, exp_q.pop_front()});
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: apply inputs, step model, check next cycle.
    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [3:0] k);
        if (t_hold) begin
            v = 1'b1; d = t_hd; k = t_hk;
        end
        bus.s_valid_i = v;
        bus.s_data_i  = d;
        bus.s_datak_i = k;
        t_hold = v && m_skp_now();
        t_hd = d; t_hk = k;
        model_step(v, d, k);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [35:0] rand_word();
        int unsigned r;
        logic [31:0] d;
        logic [1:0]  p;
        r = $urandom_range(0, 9);
        d = $urandom;
        p = 2'($urandom_range(0, 3));
        case (r)
            0: return {4'b0001, d[31:8], 8'hFB};
            1: begin
                d[8*p +: 8] = ($urandom_range(0, 1) == 0) ? 8'hFD : 8'hFE;
                return {4'(1 << p), d};
            end
            2: return {4'($urandom_range(0, 15)), d};
            default: return {4'b0000, d};
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int first_skp;
        logic [35:0] w;
        bus.s_valid_i = 0; bus.s_data_i = '0; bus.s_datak_i = '0;
        model_reset();

        // Reset state held across edges.
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Idle: SKP on cycles 9, 17, 25; ready low on 8, 16, 24.
        for (int i = 1; i <= 26; i++) begin
            drive_cycle(0, '0, '0);
            if (i == 9 || i == 17 || i == 25) chk("idle_skp", {32'd0, bus.indata_o}, {32'd0, SKP});
            if (i == 8 || i == 16 || i == 24) chk("idle_stall", {63'd0, bus.s_ready_o}, 64'd0);
        end

        // Continuous zero-word streaming.
        for (int i = 0; i < 30; i++) drive_cycle(1, 32'h0, 4'h0);
        drive_cycle(0, '0, '0);
        chk("stream_drain", {63'd0, 1'(exp_q.size())}, 64'd0);

        // Async reset mid-stream with a request pending.
        for (int i = 0; i < 3 * N && !m_pend; i++) drive_cycle(1, 32'h12345678 + i, 4'h0);
        chk("pend_reached", {63'd0, m_pend}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_indata", {32'd0, bus.indata_o}, 64'd0);
        chk("async_datak",  {60'd0, bus.datak_o},  64'd0);
        chk("async_valid",  {63'd0, bus.out_valid_o}, 64'd0);
        chk("async_ready",  {63'd0, bus.s_ready_o}, 64'd1);
        bus.s_valid_i = 0; bus.s_data_i = '0; bus.s_datak_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        first_skp = -1;
        for (int i = 1; i <= int'(N) + 3; i++) begin
            drive_cycle(0, '0, '0);
            if (first_skp < 0 && bus.indata_o == SKP) first_skp = i;
        end
        chk("post_reset_skp", 64'(first_skp), 64'(N + 1));

        // STP+END in one word while a request is pending inside a packet.
        drive_cycle(1, 32'h000000FB, 4'b0001);
        for (int i = 0; i < 3 * N && !m_pend; i++) drive_cycle(1, $urandom, 4'h0);
        drive_cycle(1, 32'hFD0000FB, 4'b1001);
        drive_cycle(0, '0, '0);
`ifdef TXSKP_PKT_GUARD_EN
        chk("stpend_skp", {32'd0, bus.indata_o}, {32'd0, SKP});
`endif
        for (int i = 0; i < 2 * N; i++) drive_cycle(0, '0, '0);

        // Packet spanning more than one interval.
        drive_cycle(1, 32'h000000FB, 4'b0001);
        for (int i = 0; i < 20; i++) drive_cycle(1, $urandom, 4'h0);
        drive_cycle(1, 32'hFD000000, 4'b1000);
        while (t_hold) drive_cycle(0, '0, '0);
        drive_cycle(0, '0, '0);
        chk("pkt_ovf", {63'd0, skp_ovf}, {63'd0, GUARD});
        for (int i = 0; i < N; i++) drive_cycle(0, '0, '0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            w = rand_word();
            drive_cycle(1'($urandom_range(0, 3) != 0), w[31:0], w[35:32]);
        end
        while (t_hold) drive_cycle(0, '0, '0);
        drive_cycle(0, '0, '0);
        chk("final_drain", {63'd0, 1'(exp_q.size())}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
